// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array drain path.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF    = 16;
    localparam int SYSTOLIC_SIZE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        CLEAR,
        SEND,
        DONE
    } state_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // ReLU on one element: a negative value is forced to zero only when enabled.
    function automatic logic relu_zero(input logic sign, input logic en);
        return sign & en;
    endfunction

endpackage

// File: rtl/ofm_column_buffer.sv
// Holds one drained tile: one entry per array column, each entry a full row-packed column.
// Write lands on the next clock edge; read is combinational. There is no flow control.
// Contents are not reset, because every entry is rewritten before it is read.
module ofm_column_buffer
    import systolic_pkg::*;
#(
    parameter  int DEPTH = SYSTOLIC_SIZE_DEF,
    parameter  int WIDTH = SYSTOLIC_SIZE_DEF * DATA_WIDTH_DEF,
    localparam int AW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ofm_collector.sv
// Drains one tile from the systolic array, applies optional ReLU, clears the PEs, then streams the columns out.
// Latency: the first out_valid comes S+3 cycles after start. Best-case tile time is 2S+4 cycles.
// Backpressure: out_ready low stalls the current beat and holds it stable. A start that arrives while busy is dropped.
module ofm_collector
    import systolic_pkg::*;
#(
    parameter  int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter  int SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
    localparam int CNT_W         = cnt_width(SYSTOLIC_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                relu_en,
    output logic                                write_out_en,
    output logic                                reset_pe,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ofm_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                    out_col_idx,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done
);

    localparam int               ROW_W    = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYSTOLIC_SIZE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             shift_on_q, shift_on_d;
    logic             cap_en_q, cap_en_d;
    logic             relu_q, relu_d;

    logic [ROW_W-1:0] cap_dat;
    logic [ROW_W-1:0] rd_dat;
    logic             buf_wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_cnt_q   <= '0;
            cap_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            shift_on_q <= 1'b0;
            cap_en_q   <= 1'b0;
            relu_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            shift_on_q <= shift_on_d;
            cap_en_q   <= cap_en_d;
            relu_q     <= relu_d;
        end
    end

    // The array output is registered, so each column arrives one cycle after its shift pulse.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        shift_on_d = shift_on_q;
        relu_d     = relu_q;
        cap_en_d   = write_out_en;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRAIN;
                    relu_d     = relu_en;
                    sh_cnt_d   = '0;
                    cap_cnt_d  = '0;
                    rd_cnt_d   = '0;
                    shift_on_d = 1'b1;
                end
            end
            DRAIN: begin
                if (shift_on_q) begin
                    if (sh_cnt_q == LAST_IDX) begin
                        shift_on_d = 1'b0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + CNT_W'(1);
                    end
                end
                if (cap_en_q) begin
                    if (cap_cnt_q == LAST_IDX) begin
                        state_d = CLEAR;
                    end else begin
                        cap_cnt_d = cap_cnt_q + CNT_W'(1);
                    end
                end
            end
            CLEAR: begin
                state_d  = SEND;
                rd_cnt_d = '0;
            end
            SEND: begin
                if (out_ready) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        write_out_en = (state_q == DRAIN) && shift_on_q;
        reset_pe     = (state_q == CLEAR);
        out_valid    = (state_q == SEND);
        out_data     = out_valid ? rd_dat : '0;
        out_col_idx  = out_valid ? rd_cnt_q : '0;
        out_last     = out_valid && (rd_cnt_q == LAST_IDX);
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        buf_wr_en    = (state_q == DRAIN) && cap_en_q;
    end

    always_comb begin
        cap_dat = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            cap_dat[r*DATA_WIDTH +: DATA_WIDTH] =
                relu_zero(ofm_in[r*DATA_WIDTH + DATA_WIDTH - 1], relu_q) ?
                '0 : ofm_in[r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    ofm_column_buffer #(
        .DEPTH (SYSTOLIC_SIZE),
        .WIDTH (ROW_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (cap_cnt_q),
        .wr_data (cap_dat),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_dat)
    );

endmodule

// File: tb/tb_ofm_collector.sv
// Bench for ofm_collector. It models the registered array output and keeps a scoreboard of the expected columns.
module tb_ofm_collector;

    localparam int DW   = 16;
    localparam int S    = 16;
    localparam int CW   = 4;
    localparam int RW   = S * DW;
    localparam int MAXC = 400;

    typedef struct packed {
        logic [RW-1:0] dat;
        logic [CW-1:0] idx;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          relu_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [RW-1:0] ofm_in = '0;
    logic          write_out_en, reset_pe, out_valid, out_last, busy, done;
    logic [RW-1:0] out_data;
    logic [CW-1:0] out_col_idx;

    int    checks = 0;
    int    passed = 0;
    beat_t exp_q[$];
    int    mode = 0;
    bit    tb_relu = 1'b0;
    int    shift_k = 0;

    int  first_valid, rpe_cyc, done_cyc, first_woe, last_woe;
    int  woe_n, rpe_n, done_n, beat_n;
    bit  timed_out, idle_after;
    logic [5:0]    post_rst_ctl;
    logic [RW-1:0] post_rst_dat;
    logic [CW-1:0] post_rst_idx;

    always #5 clk = ~clk;

    ofm_collector dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .relu_en      (relu_en),
        .write_out_en (write_out_en),
        .reset_pe     (reset_pe),
        .ofm_in       (ofm_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_col_idx  (out_col_idx),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [DW-1:0] elem(input int m, input int i, input int k);
        case (m)
            1:       return ((i + k) % 2 == 1) ? 16'h0005 : 16'hFFFE;
            2:       return 16'(32'hC000 + 256 * i + 3 * k);
            default: return 16'(256 * i + k);
        endcase
    endfunction

    // Starts a tile in the current cycle (cycle 0) and runs it cycle by cycle. The array model and the
    // scoreboard live here. Inputs change 1 time unit after each rising edge, and outputs are sampled then too.
    task automatic run_tile(input int pct, input int ra, input int rb, input bit tog, input int rst_col);
        bit            woe_prev = 1'b0;
        bit            stall = 1'b0;
        logic [RW-1:0] s_dat = '0;
        logic [CW-1:0] s_idx = '0;
        logic          s_last = 1'b0;
        int            rst_at = -1;
        beat_t         eb;
        beat_t         got;
        logic [RW-1:0] col;
        logic [DW-1:0] ev;
        first_valid = -1; rpe_cyc = -1; done_cyc = -1; first_woe = -1; last_woe = -1;
        woe_n = 0; rpe_n = 0; done_n = 0; beat_n = 0;
        timed_out = 1'b1; idle_after = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clk);
            #1;
            if (woe_prev) begin
                col = '0;
                eb  = '0;
                for (int i = 0; i < S; i++) begin
                    ev = elem(mode, i, shift_k % S);
                    col[i*DW +: DW]    = ev;
                    eb.dat[i*DW +: DW] = (tb_relu && ev[DW-1]) ? '0 : ev;
                end
                eb.idx  = CW'(shift_k % S);
                eb.last = ((shift_k % S) == S - 1);
                exp_q.push_back(eb);
                ofm_in  = col;
                shift_k = shift_k + 1;
            end
            start = (c == ra) || (c == rb);
            rst   = 1'b0;
            if (tog) relu_en = ~relu_en;
            out_ready = ($urandom_range(0, 99) < pct);
            if (rst_at >= 0) begin
                if (c == rst_at + 1) begin
                    post_rst_ctl = {write_out_en, reset_pe, out_valid, out_last, busy, done};
                    post_rst_dat = out_data;
                    post_rst_idx = out_col_idx;
                    exp_q.delete();
                end
                if (c == rst_at + 5) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== s_dat || out_col_idx !== s_idx || out_last !== s_last)
                    $display("FAIL stall_hold: cycle %0d got valid=%b idx=%0d last=%b data=%h, required valid=1 idx=%0d last=%b data=%h",
                             c, out_valid, out_col_idx, out_last, out_data, s_idx, s_last, s_dat);
                else
                    passed++;
            end
            stall  = out_valid && !out_ready;
            s_dat  = out_data;
            s_idx  = out_col_idx;
            s_last = out_last;
            if (write_out_en) begin
                woe_n++;
                if (first_woe < 0) first_woe = c;
                last_woe = c;
            end
            woe_prev = write_out_en;
            if (reset_pe) begin
                rpe_n++;
                if (rpe_cyc < 0) rpe_cyc = c;
            end
            if (done) begin
                done_n++;
                done_cyc = c;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (rst_col >= 0 && rst_at < 0 && out_valid && out_col_idx == CW'(rst_col)) begin
                rst       = 1'b1;
                out_ready = 1'b0;
                stall     = 1'b0;
                rst_at    = c;
            end else if (out_valid && out_ready) begin
                checks++;
                got = {out_data, out_col_idx, out_last};
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_unexpected: cycle %0d got idx=%0d, required no beat", c, out_col_idx);
                end else begin
                    eb = exp_q.pop_front();
                    if (got !== eb)
                        $display("FAIL beat: cycle %0d got idx=%0d last=%b data=%h, required idx=%0d last=%b data=%h",
                                 c, out_col_idx, out_last, out_data, eb.idx, eb.last, eb.dat);
                    else
                        passed++;
                end
                beat_n++;
            end
            if (rst_at < 0 && done_cyc >= 0 && c == done_cyc + 1) begin
                idle_after = !busy;
                timed_out  = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (timed_out) $display("FAIL tile_timeout: got no completion within %0d cycles, required completion", MAXC);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({write_out_en, reset_pe, out_valid, out_last, busy, done} !== 6'b0)
            $display("FAIL reset_ctl: got %b, required 000000",
                     {write_out_en, reset_pe, out_valid, out_last, busy, done});
        else passed++;
        checks++;
        if (out_data !== '0) $display("FAIL reset_data: got %h, required 0", out_data);
        else passed++;
        checks++;
        if (out_col_idx !== '0) $display("FAIL reset_idx: got %0d, required 0", out_col_idx);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_no_start: got busy=%b, required 0", busy);
        else passed++;
    endtask

    task automatic test_basic_drain();
        mode = 0; tb_relu = 1'b0; relu_en = 1'b0;
        run_tile(100, -1, -1, 1'b0, -1);
        checks++;
        if (woe_n !== S || first_woe !== 1 || last_woe !== S)
            $display("FAIL woe_window: got count=%0d first=%0d last=%0d, required %0d/1/%0d", woe_n, first_woe, last_woe, S, S);
        else passed++;
        checks++;
        if (rpe_n !== 1 || rpe_cyc !== S + 2)
            $display("FAIL reset_pe: got count=%0d cycle=%0d, required 1/%0d", rpe_n, rpe_cyc, S + 2);
        else passed++;
        checks++;
        if (first_valid !== S + 3) $display("FAIL latency: got %0d, required %0d", first_valid, S + 3);
        else passed++;
        checks++;
        if (beat_n !== S || exp_q.size() !== 0)
            $display("FAIL beat_count: got beats=%0d left=%0d, required %0d/0", beat_n, exp_q.size(), S);
        else passed++;
        checks++;
        if (done_n !== 1 || done_cyc !== 2 * S + 3)
            $display("FAIL done_pulse: got count=%0d cycle=%0d, required 1/%0d", done_n, done_cyc, 2 * S + 3);
        else passed++;
        checks++;
        if (idle_after !== 1'b1) $display("FAIL idle_after_done: got busy, required idle");
        else passed++;
    endtask

    task automatic test_relu();
        mode = 1; tb_relu = 1'b1; relu_en = 1'b1;
        run_tile(100, -1, -1, 1'b1, -1);
        relu_en = 1'b0;
        checks++;
        if (beat_n !== S || exp_q.size() !== 0)
            $display("FAIL relu_beats: got beats=%0d left=%0d, required %0d/0", beat_n, exp_q.size(), S);
        else passed++;
    endtask

    task automatic test_backpressure();
        mode = 2; tb_relu = 1'b0; relu_en = 1'b0;
        run_tile(30, -1, -1, 1'b0, -1);
        checks++;
        if (beat_n !== S || exp_q.size() !== 0 || done_n !== 1)
            $display("FAIL bp_beats: got beats=%0d left=%0d done=%0d, required %0d/0/1", beat_n, exp_q.size(), done_n, S);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        mode = 0; tb_relu = 1'b0; relu_en = 1'b0;
        run_tile(100, 5, 25, 1'b0, -1);
        checks++;
        if (woe_n !== S || done_n !== 1 || beat_n !== S || idle_after !== 1'b1)
            $display("FAIL busy_start: got woe=%0d done=%0d beats=%0d idle=%b, required %0d/1/%0d/1",
                     woe_n, done_n, beat_n, idle_after, S, S);
        else passed++;
    endtask

    task automatic test_reset_mid_send();
        mode = 0; tb_relu = 1'b0; relu_en = 1'b0;
        run_tile(100, -1, -1, 1'b0, 7);
        checks++;
        if (post_rst_ctl !== 6'b0 || post_rst_dat !== '0 || post_rst_idx !== '0)
            $display("FAIL mid_reset_outputs: got ctl=%b idx=%0d data=%h, required all zero",
                     post_rst_ctl, post_rst_idx, post_rst_dat);
        else passed++;
        checks++;
        if (done_n !== 0 || beat_n !== 7)
            $display("FAIL mid_reset_done: got done=%0d beats=%0d, required 0/7", done_n, beat_n);
        else passed++;
        run_tile(100, -1, -1, 1'b0, -1);
        checks++;
        if (beat_n !== S || done_n !== 1 || exp_q.size() !== 0)
            $display("FAIL fresh_tile: got beats=%0d done=%0d left=%0d, required %0d/1/0", beat_n, done_n, exp_q.size(), S);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_relu();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
